sr_register_bank: RTL

//  WIDTH-channel clocked set/reset storage bank. Each channel has its own s/r pair.
//  The s=r=1 conflict resolves by a runtime mode, never to X.

---
 rtl/sr_register_bank_pkg.sv | 32 +++
 rtl/sr_register_bank_if.sv | 28 ++
 rtl/sr_register_bank_cell.sv | 39 +++
 rtl/sr_register_bank_chk.sv | 53 +++++
 rtl/sr_register_bank.sv | 76 +++++++
 5 files changed

// File: rtl/sr_register_bank_pkg.sv
// Shared types and next-state rule for the SR register bank.
// The same rule drives the storage cells and the bound checker.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    SR_HOLD      = 2'b00,
    SR_SET_DOM   = 2'b01,
    SR_RESET_DOM = 2'b10,
    SR_TOGGLE    = 2'b11
  } sr_mode_e;

  // Single-channel next state; the s=r=1 case is resolved by mode, never X.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_e mode);
    logic n;
    case ({s, r})
      2'b00:   n = q;
      2'b01:   n = 1'b0;
      2'b10:   n = 1'b1;
      default: begin
        case (mode)
          SR_HOLD:      n = q;
          SR_SET_DOM:   n = 1'b1;
          SR_RESET_DOM: n = 1'b0;
          default:      n = ~q;
        endcase
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sr_register_bank_if.sv
// Request/status bundle of the SR register bank.
interface sr_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  import sr_bank_pkg::*;

  logic             enable;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  sr_mode_e         mode;
  logic             clear_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] conflict_now;
  logic             conflict_flag;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output enable, s, r, mode, clear_err,
    input  q, q_bar, conflict_now, conflict_flag, conflict_cnt
  );

  modport slave (
    input  enable, s, r, mode, clear_err,
    output q, q_bar, conflict_now, conflict_flag, conflict_cnt
  );
endinterface

// File: rtl/sr_register_bank_cell.sv
// One SR channel: q and q_bar are separate flops fed from the same next state,
// so q_bar is registered yet can never drift from ~q.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     en_i,
  input  logic     s_i,
  input  logic     r_i,
  input  sr_mode_e mode_i,
  output logic     q_o,
  output logic     q_bar_o
);

  logic q_q, q_d;
  logic qb_q;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = sr_next(q_q, s_i, r_i, mode_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_q  <= RST_VAL;
      qb_q <= ~RST_VAL;
    end else begin
      q_q  <= q_d;
      qb_q <= ~q_d;
    end
  end

  assign q_o     = q_q;
  assign q_bar_o = qb_q;

endmodule

// File: rtl/sr_register_bank_chk.sv
// Bound checker: q_bar mirrors ~q, and q follows the shared next-state rule.
module sr_bank_chk
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic             clk,
  input logic             rst_n,
  input logic             en,
  input logic [WIDTH-1:0] s,
  input logic [WIDTH-1:0] r,
  input sr_mode_e         mode,
  input logic [WIDTH-1:0] q,
  input logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] exp_q;
  logic             vld_q;

  always_comb begin
    nxt = q;
    for (int i = 0; i < WIDTH; i++) nxt[i] = sr_next(q[i], s[i], r[i], mode);
  end

  // Checks compare pre-edge values: exp_q was predicted on the previous edge.
  always_ff @(posedge clk) begin
    if (vld_q) begin
      assert (q_bar == ~q);
      assert (q == exp_q);
    end
    vld_q <= vld_q | ~rst_n;
    if (!rst_n)  exp_q <= RESET_VALUE;
    else if (en) exp_q <= nxt;
    else         exp_q <= q;
  end

endmodule

bind sr_register_bank sr_bank_chk #(
  .WIDTH       (WIDTH),
  .RESET_VALUE (RESET_VALUE)
) u_chk (
  .clk   (clock_pulse),
  .rst_n (reset_n),
  .en    (en_w),
  .s     (s_w),
  .r     (r_w),
  .mode  (mode_w),
  .q     (q_w),
  .q_bar (qb_w)
);

// File: rtl/sr_register_bank.sv
// WIDTH-channel SR storage bank with runtime conflict policy and a
// saturating conflict counter plus sticky flag for status logic.
module sr_register_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              clock_pulse,
  input logic              reset_n,
  sr_register_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             en_w;
  logic [WIDTH-1:0] s_w, r_w, q_w, qb_w, cnow_w;
  sr_mode_e         mode_w;
  logic             conflict_cyc;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  assign en_w   = bus.enable;
  assign s_w    = bus.s;
  assign r_w    = bus.r;
  assign mode_w = bus.mode;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(.RST_VAL(RESET_VALUE[i])) u_cell (
      .clk_i   (clock_pulse),
      .rst_n_i (reset_n),
      .en_i    (en_w),
      .s_i     (s_w[i]),
      .r_i     (r_w[i]),
      .mode_i  (mode_w),
      .q_o     (q_w[i]),
      .q_bar_o (qb_w[i])
    );
  end

  assign cnow_w       = {WIDTH{en_w}} & s_w & r_w;
  assign conflict_cyc = |cnow_w;

  // A conflict on the same edge as clear_err wins: the fresh event is kept.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (conflict_cyc) begin
      flag_d = 1'b1;
      if (bus.clear_err)        cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.clear_err) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clock_pulse) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign bus.q             = q_w;
  assign bus.q_bar         = qb_w;
  assign bus.conflict_now  = cnow_w;
  assign bus.conflict_flag = flag_q;
  assign bus.conflict_cnt  = cnt_q;

endmodule
